// File: rtl/fpnew_fma_out_stage.sv
// fpnew_fma_out_stage
//
// Elastic output pipeline for the FMA unit. The FMA result, its exception
// flags and an opaque operation tag travel through NumPipeRegs register stages
// with valid/ready handshaking. At the output the format-width result is
// NaN-boxed (upper bits set to one) into the full Width-bit datapath.
//
// FpFormat uses the fpnew fp_format_e encoding:
//   0 = FP32, 1 = FP64, 2 = FP16, 3 = FP8, 4 = FP16ALT
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   flush_i             synchronous flush, kills every in-flight op
//   in_valid_i/in_ready_o  upstream handshake (from the FMA)
//   result_i, status_i, tag_i  FMA result, {NV,DZ,OF,UF,NX} flags, tag
//   out_valid_o/out_ready_i  downstream handshake
//   result_o, status_o, tag_o  NaN-boxed result, flags, tag of the output op
//   busy_o              some stage holds a valid op
module fpnew_fma_out_stage #(
    parameter logic [2:0]  FpFormat    = 3'd0,
    parameter int unsigned Width       = 64,
    parameter int unsigned NumPipeRegs = 2,
    parameter int unsigned TagWidth    = 4,
    localparam int unsigned FpWidth    = (FpFormat == 3'd1) ? 64 :
                                         (FpFormat == 3'd2) ? 16 :
                                         (FpFormat == 3'd3) ? 8  :
                                         (FpFormat == 3'd4) ? 16 : 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [FpWidth-1:0]  result_i,
    input  logic [4:0]          status_i,
    input  logic [TagWidth-1:0] tag_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [Width-1:0]    result_o,
    output logic [4:0]          status_o,
    output logic [TagWidth-1:0] tag_o,
    output logic                busy_o
);

    localparam int unsigned PadWidth = (Width > FpWidth) ? Width - FpWidth : 0;

    if (Width < FpWidth) begin : gen_width_err
        $error("fpnew_fma_out_stage: Width is smaller than the format width");
    end

    // Result of the op currently presented at the output, before NaN-boxing.
    logic [FpWidth-1:0] last_result;

    if (PadWidth > 0) begin : gen_nan_box
        assign result_o = {{PadWidth{1'b1}}, last_result};
    end else begin : gen_no_box
        assign result_o = last_result;
    end

    if (NumPipeRegs == 0) begin : gen_passthrough
        assign out_valid_o = in_valid_i;
        assign in_ready_o  = out_ready_i;
        assign last_result = result_i;
        assign status_o    = status_i;
        assign tag_o       = tag_i;
        assign busy_o      = 1'b0;

        logic unused_passthrough;
        assign unused_passthrough = ^{clk_i, rst_ni, flush_i};
    end else begin : gen_pipe
        localparam int unsigned N = NumPipeRegs;

        logic [N-1:0]               valid_q, valid_d;
        logic [N-1:0]               ready;
        logic [N-1:0]               load;
        logic [N-1:0][FpWidth-1:0]  result_q;
        logic [N-1:0][4:0]          status_q;
        logic [N-1:0][TagWidth-1:0] tag_q;

        // Entry i of each chain is what stage i loads from: the module inputs
        // for stage 0, the previous stage otherwise. Entry N is never loaded.
        logic [N:0]                 chain_valid;
        logic [N:0][FpWidth-1:0]    chain_result;
        logic [N:0][4:0]            chain_status;
        logic [N:0][TagWidth-1:0]   chain_tag;

        assign chain_valid  = {valid_q, in_valid_i};
        assign chain_result = {result_q, result_i};
        assign chain_status = {status_q, status_i};
        assign chain_tag    = {tag_q, tag_i};

        logic unused_chain;
        assign unused_chain = ^{chain_valid[N], chain_result[N], chain_status[N], chain_tag[N]};

        // ready[i] = ~valid_q[i] | ready[i+1], unrolled as "some stage from i to
        // the output is empty, or the output is draining" to avoid a
        // self-referencing combinational vector.
        always_comb begin
            logic tail_full;
            tail_full = 1'b1;
            ready     = '0;
            for (int i = int'(N) - 1; i >= 0; i--) begin
                tail_full = tail_full & valid_q[i];
                ready[i]  = out_ready_i | ~tail_full;
            end
        end

        always_comb begin
            valid_d = valid_q;
            load    = '0;
            for (int i = 0; i < int'(N); i++) begin
                load[i] = chain_valid[i] & ready[i];
                if (flush_i) begin
                    valid_d[i] = 1'b0;
                end else if (ready[i]) begin
                    valid_d[i] = chain_valid[i];
                end
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                valid_q  <= '0;
                result_q <= '0;
                status_q <= '0;
                tag_q    <= '0;
            end else begin
                valid_q <= valid_d;
                for (int i = 0; i < int'(N); i++) begin
                    if (load[i]) begin
                        result_q[i] <= chain_result[i];
                        status_q[i] <= chain_status[i];
                        tag_q[i]    <= chain_tag[i];
                    end
                end
            end
        end

        assign in_ready_o  = ready[0];
        assign out_valid_o = valid_q[N-1];
        assign last_result = result_q[N-1];
        assign status_o    = status_q[N-1];
        assign tag_o       = tag_q[N-1];
        assign busy_o      = |valid_q;
    end

endmodule
